// File: rtl/selection_sort_ctrl.sv
// Outer-loop controller for in-memory selection sort; drives the Update_J inner counter.
// Optional macro SORT_SIGNED_EN selects a two's-complement element compare.
module selection_sort_ctrl #(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_num_elems,
    output logic                 o_j_start,
    output logic                 o_j_en,
    output logic [SIZE_ADDR-1:0] o_value_i,
    input  logic [SIZE_ADDR-1:0] i_value_j,
    input  logic                 i_j_done,
    output logic [SIZE_ADDR-1:0] o_mem_addr,
    output logic                 o_mem_rd,
    input  logic [SIZE_DATA-1:0] i_mem_rdata,
    output logic                 o_mem_we,
    output logic [SIZE_DATA-1:0] o_mem_wdata,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        WAIT_I,
        SCAN,
        SWAP_A,
        SWAP_B,
        NEXT_I,
        DONE
    } state_t;

    state_t               state_q;
    logic [SIZE_ADDR-1:0] i_q;
    logic [SIZE_ADDR-1:0] r_n_q;
    logic [SIZE_ADDR-1:0] r_min_idx_q;
    logic [SIZE_ADDR-1:0] r_cmp_idx_q;
    logic [SIZE_DATA-1:0] r_min_val_q;
    logic [SIZE_DATA-1:0] r_val_i_q;
    logic                 r_cmp_vld_q;
    logic                 less;

`ifdef SORT_SIGNED_EN
    assign less = $signed(i_mem_rdata) < $signed(r_min_val_q);
`else
    assign less = i_mem_rdata < r_min_val_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            r_n_q       <= '0;
            r_min_idx_q <= '0;
            r_cmp_idx_q <= '0;
            r_min_val_q <= '0;
            r_val_i_q   <= '0;
            r_cmp_vld_q <= 1'b0;
        end else begin
            // Read data for the element addressed last cycle arrives now.
            if (r_cmp_vld_q && less) begin
                r_min_val_q <= i_mem_rdata;
                r_min_idx_q <= r_cmp_idx_q;
            end
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        r_n_q   <= i_num_elems;
                        i_q     <= '0;
                        state_q <= (i_num_elems < SIZE_ADDR'(2)) ? DONE : LOAD_I;
                    end
                end
                LOAD_I: state_q <= WAIT_I;
                WAIT_I: begin
                    r_min_val_q <= i_mem_rdata;
                    r_val_i_q   <= i_mem_rdata;
                    r_min_idx_q <= i_q;
                    state_q     <= SCAN;
                end
                SCAN: begin
                    if (!i_j_done) begin
                        r_cmp_idx_q <= i_value_j;
                        r_cmp_vld_q <= 1'b1;
                    end else begin
                        r_cmp_vld_q <= 1'b0;
                        // One drain cycle lets the last compare settle r_min_idx_q.
                        if (!r_cmp_vld_q)
                            state_q <= (r_min_idx_q == i_q) ? NEXT_I : SWAP_A;
                    end
                end
                SWAP_A: state_q <= SWAP_B;
                SWAP_B: state_q <= NEXT_I;
                NEXT_I: begin
                    if (i_q == r_n_q - SIZE_ADDR'(2)) begin
                        state_q <= DONE;
                    end else begin
                        i_q     <= i_q + SIZE_ADDR'(1);
                        state_q <= LOAD_I;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_value_i = i_q;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);
    assign o_j_start = (state_q == WAIT_I);

    // SCAN reads follow the live j value, so these strobes decode state plus Update_J outputs.
    always_comb begin
        o_j_en      = 1'b0;
        o_mem_rd    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (state_q)
            LOAD_I: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = i_q;
            end
            SCAN: begin
                if (!i_j_done) begin
                    o_mem_rd   = 1'b1;
                    o_mem_addr = i_value_j;
                    o_j_en     = 1'b1;
                end
            end
            SWAP_A: begin
                o_mem_we    = !i_rst;
                o_mem_addr  = r_min_idx_q;
                o_mem_wdata = r_val_i_q;
            end
            SWAP_B: begin
                o_mem_we    = !i_rst;
                o_mem_addr  = i_q;
                o_mem_wdata = r_min_val_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_selection_sort_ctrl.sv
// Directed bench for selection_sort_ctrl with Update_J and single-port RAM models.
// Expectations follow SORT_SIGNED_EN when the macro is defined for the build.
module tb_selection_sort_ctrl;

    typedef struct {
        int              n;
        logic [4:0][31:0] init;
        logic [4:0][31:0] exp;
        int              wr;
        int              lat;
        int              fwa;
        logic [31:0]     fwd;
    } vec_t;

    localparam int NV = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num = '0;
    logic        j_start, j_en, j_done, rd, we, busy, done;
    logic [7:0]  val_i, val_j, addr;
    logic [31:0] rdata = '0;
    logic [31:0] wdata;

    logic [7:0]       jq = '0;
    logic [7:0]       n_model = '0;
    logic [31:0]      mem [256];
    logic [7:0][31:0] img = '0;
    logic             ld = 1'b0;

    int wr_tot = 0, rd_tot = 0, js_tot = 0, je_tot = 0, coll_tot = 0, proto_tot = 0, busy_tot = 0;
    logic [7:0]  wlog_a [1024];
    logic [31:0] wlog_d [1024];

    int   n_chk = 0;
    int   n_err = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    selection_sort_ctrl #(.SIZE_ADDR(8), .SIZE_DATA(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_elems(num),
        .o_j_start(j_start), .o_j_en(j_en), .o_value_i(val_i),
        .i_value_j(val_j), .i_j_done(j_done),
        .o_mem_addr(addr), .o_mem_rd(rd), .i_mem_rdata(rdata),
        .o_mem_we(we), .o_mem_wdata(wdata), .o_busy(busy), .o_done(done)
    );

    // Update_J: j loads i+1 on start, counts on enable, done when j==N.
    always @(posedge clk) begin
        if (rst) jq <= '0;
        else if (j_start) jq <= val_i + 8'd1;
        else if (j_en) jq <= jq + 8'd1;
    end
    assign val_j  = jq;
    assign j_done = (jq == n_model);

    always @(posedge clk) begin
        if (ld) begin
            for (int k = 0; k < 8; k++) mem[k] <= img[k];
        end else begin
            if (we) mem[addr] <= wdata;
            if (rd) rdata <= mem[addr];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (we) begin
                wlog_a[wr_tot % 1024] <= addr;
                wlog_d[wr_tot % 1024] <= wdata;
                wr_tot <= wr_tot + 1;
            end
            if (rd) rd_tot <= rd_tot + 1;
            if (j_start) js_tot <= js_tot + 1;
            if (j_en) je_tot <= je_tot + 1;
            if (we && rd) coll_tot <= coll_tot + 1;
            if (j_en && (addr != val_j || !rd)) proto_tot <= proto_tot + 1;
            if (busy) busy_tot <= busy_tot + 1;
        end
    end

    function automatic bit lt(input logic [31:0] a, input logic [31:0] b);
`ifdef SORT_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input int wr, input int lat, input int fwa,
                                input logic [31:0] fwd,
                                input logic [31:0] a0, a1, a2, a3, a4,
                                input logic [31:0] e0, e1, e2, e3, e4);
        vec_t v;
        v.n = n; v.wr = wr; v.lat = lat; v.fwa = fwa; v.fwd = fwd;
        v.init[0] = a0; v.init[1] = a1; v.init[2] = a2; v.init[3] = a3; v.init[4] = a4;
        v.exp[0]  = e0; v.exp[1]  = e1; v.exp[2]  = e2; v.exp[3]  = e3; v.exp[4]  = e4;
        return v;
    endfunction

    task automatic load_img(input logic [7:0][31:0] d);
        @(posedge clk); #1;
        img = d;
        ld  = 1'b1;
        @(posedge clk); #1;
        ld  = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic [7:0][31:0] d;
        int cyc, wb, rb, jsb, jeb, cb, pb, bb, njs, nje;
        v = vecs[idx];
        d = '0;
        for (int k = 0; k < 5; k++) d[k] = v.init[k];
        load_img(d);
        @(posedge clk); #1;
        n_model = 8'(v.n);
        num     = 8'(v.n);
        start   = 1'b1;
        wb = wr_tot; rb = rd_tot; jsb = js_tot; jeb = je_tot;
        cb = coll_tot; pb = proto_tot; bb = busy_tot;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        chk($sformatf("v%0d.latency", idx), 64'(cyc), 64'(v.lat));
        @(negedge clk);
        chk($sformatf("v%0d.idle_after", idx), 64'({busy, done}), 64'(0));
        #1;
        njs = (v.n < 2) ? 0 : v.n - 1;
        nje = (v.n < 2) ? 0 : v.n * (v.n - 1) / 2;
        chk($sformatf("v%0d.writes", idx), 64'(wr_tot - wb), 64'(v.wr));
        chk($sformatf("v%0d.j_starts", idx), 64'(js_tot - jsb), 64'(njs));
        chk($sformatf("v%0d.j_ens", idx), 64'(je_tot - jeb), 64'(nje));
        chk($sformatf("v%0d.reads", idx), 64'(rd_tot - rb), 64'(njs + nje));
        chk($sformatf("v%0d.rd_we_overlap", idx), 64'(coll_tot - cb), 64'(0));
        chk($sformatf("v%0d.scan_addr", idx), 64'(proto_tot - pb), 64'(0));
        chk($sformatf("v%0d.busy_cycles", idx), 64'(busy_tot - bb), 64'(v.lat));
        if (v.fwa >= 0) begin
            chk($sformatf("v%0d.first_wr_addr", idx), 64'(wlog_a[wb % 1024]), 64'(v.fwa));
            chk($sformatf("v%0d.first_wr_data", idx), 64'(wlog_d[wb % 1024]), 64'(v.fwd));
        end
        for (int k = 0; k < 5; k++)
            chk($sformatf("v%0d.ram[%0d]", idx, k), 64'(mem[k]), 64'(v.exp[k]));
    endtask

    initial begin
        logic [7:0][31:0] d;
        logic [31:0] ref_a [8];
        logic [31:0] t;
        int cyc, jsb, cb, wb, p;

        vecs[0] = mk(2, 2,  9, 1, 32'd5, 5, 3, 0, 0, 0,  3, 5, 0, 0, 0);
        vecs[1] = mk(4, 4, 26, 1, 32'd9, 9, 2, 7, 2, 0,  2, 2, 7, 9, 0);
        vecs[2] = mk(4, 0, 22, -1, 32'd0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0);
        vecs[3] = mk(0, 0,  1, -1, 32'd0, 7, 6, 0, 0, 0, 7, 6, 0, 0, 0);
        vecs[4] = mk(1, 0,  1, -1, 32'd0, 7, 6, 0, 0, 0, 7, 6, 0, 0, 0);
        vecs[5] = mk(3, 4, 18, 1, 32'd3, 3, 1, 2, 0, 0,  1, 2, 3, 0, 0);
        vecs[6] = mk(5, 4, 35, 4, 32'd5, 5, 4, 3, 2, 1,  1, 2, 3, 4, 5);
`ifdef SORT_SIGNED_EN
        vecs[7] = mk(2, 2,  9, 1, 32'd1, 32'h1, 32'hFFFF_FFFF, 0, 0, 0,
                     32'hFFFF_FFFF, 32'h1, 0, 0, 0);
`else
        vecs[7] = mk(2, 0,  7, -1, 32'd0, 32'h1, 32'hFFFF_FFFF, 0, 0, 0,
                     32'h1, 32'hFFFF_FFFF, 0, 0, 0);
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.ctl", 64'({busy, done, rd, we, j_start, j_en}), 64'(0));
        chk("reset.addr_i", 64'({addr, val_i}), 64'(0));
        chk("reset.wdata", 64'(wdata), 64'(0));

        for (int v = 0; v < NV; v++) run_vec(v);

        // Abort in SCAN of pass 1 with N=8.
        for (int k = 0; k < 8; k++) d[k] = 32'(8 - k);
        load_img(d);
        @(posedge clk); #1;
        n_model = 8'd8; num = 8'd8; start = 1'b1;
        jsb = js_tot;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 500) begin
            @(negedge clk); #1;
            cyc++;
            if (js_tot == jsb + 2) break;
        end
        chk("abort.reached_pass1", 64'(js_tot - jsb), 64'(2));
        @(posedge clk); #1;
        chk("abort.in_scan", 64'({j_en, rd, val_i}), 64'({1'b1, 1'b1, 8'd1}));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort.ctl", 64'({busy, done, rd, we, j_start, j_en}), 64'(0));
        chk("abort.addr_i_wdata", 64'({addr, val_i, wdata}), 64'(0));

        // Fresh N=8 random sort, with a start pulsed mid-sort that must be ignored.
        for (int k = 0; k < 8; k++) begin
            d[k] = $urandom();
            ref_a[k] = d[k];
        end
        for (int a = 1; a < 8; a++) begin
            t = ref_a[a];
            p = a;
            while (p > 0 && lt(t, ref_a[p-1])) begin
                ref_a[p] = ref_a[p-1];
                p--;
            end
            ref_a[p] = t;
        end
        load_img(d);
        @(posedge clk); #1;
        n_model = 8'd8; num = 8'd8; start = 1'b1;
        jsb = js_tot; cb = coll_tot; wb = wr_tot;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 num = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; num = 8'd8;
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        chk("rnd.done_seen", 64'(done), 64'(1));
        @(negedge clk); #1;
        chk("rnd.j_starts", 64'(js_tot - jsb), 64'(7));
        chk("rnd.rd_we_overlap", 64'(coll_tot - cb), 64'(0));
        for (int k = 0; k < 8; k++)
            chk($sformatf("rnd.ram[%0d]", k), 64'(mem[k]), 64'(ref_a[k]));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/selection_sort_ctrl.md
Name: selection_sort_ctrl

Overview:
- Outer-loop controller for the in-memory selection sort. It sits directly upstream of the inner index counter (Update_J).
- Owns index i, drives Update_J's start, enable and i-value inputs, and consumes its j value and done flag.
- Reads elements through a single-port RAM, tracks the running minimum and writes the swap pair at the end of each pass.
- Sorts i_num_elems elements, addresses 0..N-1, ascending.

Parameters:
- SIZE_ADDR, 8, width of indices, element count and RAM address.
- SIZE_DATA, 32, width of one element.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  start pulse; ignored while o_busy=1.
- i_num_elems  in  SIZE_ADDR  element count N; sampled on accepted i_start.
- o_j_start  out  1  to Update_J i_start; loads j=i+1.
- o_j_en  out  1  to Update_J i_en; advances j.
- o_value_i  out  SIZE_ADDR  to Update_J i_value_i; current i.
- i_value_j  in  SIZE_ADDR  from Update_J o_value_j.
- i_j_done  in  1  from Update_J o_done (combinational j==N).
- o_mem_addr  out  SIZE_ADDR  RAM address.
- o_mem_rd  out  1  read strobe; data valid on i_mem_rdata the next cycle.
- i_mem_rdata  in  SIZE_DATA  read data.
- o_mem_we  out  1  write strobe.
- o_mem_wdata  out  SIZE_DATA  write data.
- o_busy  out  1  high from accepted start until DONE.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: FSM=IDLE; i, r_min_idx, r_min_val, r_val_i, r_cmp_idx, r_cmp_vld, r_n all 0; every output 0.
- Reset mid-sort aborts in the next cycle. No write is issued after reset is sampled.
- IDLE:
  - i_start latches r_n=i_num_elems and sets i=0.
  - If N<2, go to DONE. Otherwise go to LOAD_I.
- LOAD_I: o_mem_rd=1, o_mem_addr=i. Go to WAIT_I.
- WAIT_I:
  - Load r_min_val=r_val_i=i_mem_rdata and r_min_idx=i.
  - Assert o_j_start for one cycle.
  - Go to SCAN. First SCAN cycle sees j=i+1.
- SCAN, when i_j_done=0:
  - o_mem_rd=1, o_mem_addr=i_value_j, o_j_en=1.
  - r_cmp_idx<=i_value_j, r_cmp_vld<=1.
- SCAN, when i_j_done=1:
  - No read and no o_j_en; r_cmp_vld<=0.
  - Leave for SWAP_A only when i_j_done=1 and r_cmp_vld=0. This is a one-cycle drain.
- Compare (every cycle r_cmp_vld=1): if i_mem_rdata < r_min_val (strict, unsigned), then r_min_val<=i_mem_rdata and r_min_idx<=r_cmp_idx. Ties keep the earlier index.
- SWAP_A:
  - If r_min_idx==i, skip to NEXT_I with no writes.
  - Otherwise o_mem_we=1, addr=r_min_idx, wdata=r_val_i.
- SWAP_B: o_mem_we=1, addr=i, wdata=r_min_val.
- NEXT_I: if i==r_n-2 go to DONE; otherwise i<=i+1 and go to LOAD_I.
- DONE: o_done=1 for one cycle, o_busy=0 next. Go to IDLE.
- Pass timing: each pass takes 2 + (N-i+1) + (2 or 0) + 1 cycles.
- Read and write never occur in the same cycle.
- o_value_i=i at all times.
- Arithmetic: r_n-2 uses SIZE_ADDR-bit unsigned math, guarded by the N<2 check. N=2^SIZE_ADDR-1 is the maximum supported count.

Optional Feature:
- Macro SORT_SIGNED_EN.
- Defined: the compare treats i_mem_rdata and r_min_val as two's-complement signed.
- Undefined: unsigned compare.
- Nothing else changes.

Test Plan:
- N=2, RAM=[5,3], pulse start -> reads addr0 then addr1; writes addr1=5 then addr0=3. o_done pulses 9 cycles after start is accepted; final RAM=[3,5].
- N=4, RAM=[9,2,7,2] -> final [2,2,7,9].
  - Pass 0 swaps index 0 with index 1, not 3 (tie keeps the earlier index).
  - o_mem_we asserted exactly 4 times (swap passes 0 and 1; pass 2 skips).
- N=4 already sorted [1,2,3,4] -> zero write strobes; o_done still pulses; per-pass SCAN length N-i+1 checked against Update_J j sequence.
- N=0 and N=1 -> o_busy and o_done each 1 cycle; no RAM strobes; no o_j_start.
- Assert i_rst while in SCAN of pass 1 with N=8 -> next cycle FSM=IDLE and all outputs 0. A following start with N=8 on random data sorts correctly against a scoreboard. A start pulsed while busy is ignored.
- With SORT_SIGNED_EN: RAM=[0x00000001, 0xFFFFFFFF] -> [0xFFFFFFFF, 0x00000001]. Without the macro: unchanged, no writes.
